// File: rtl/vx_alu_multi_pkg.sv
// vx_alu_multi_pkg: shared widths and types for the ALU multi-unit router
package vx_alu_multi_pkg;

   localparam int NUM_SUBUNITS_DEF = 2;
   localparam int MAX_PENDING_DEF  = 4;

   // sub-unit index width, never narrower than one bit
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // credit counter width able to hold 0..m
   function automatic int cnt_width(input int m);
      return $clog2(m + 1);
   endfunction

   localparam int SEL_W = sel_width(NUM_SUBUNITS_DEF);
   localparam int CNT_W = cnt_width(MAX_PENDING_DEF);

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vx_alu_rsp_arb.sv
// vx_alu_rsp_arb: locked round-robin commit arbiter with optional 2-entry skid
module vx_alu_rsp_arb
   import vx_alu_multi_pkg::*;
#(
   parameter int NUM_SUBUNITS = 2,
   parameter int RSP_DATAW    = 256,
   parameter int OUT_BUF      = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_SUBUNITS-1:0]             rsp_valid,
   input  logic [NUM_SUBUNITS*RSP_DATAW-1:0]   rsp_data,
   output logic [NUM_SUBUNITS-1:0]             rsp_ready,
   output logic                                out_valid,
   output logic [RSP_DATAW-1:0]                out_data,
   output logic [sel_width(NUM_SUBUNITS)-1:0]  out_sel,
   input  logic                                out_ready,
   output logic                                empty
);

   localparam int SEL_BITS = sel_width(NUM_SUBUNITS);

   logic                 lock_q, lock_d, gvalid, acc, fire;
   logic [SEL_BITS-1:0]  lsel_q, rr_q, rr_d, gsel;
   logic [RSP_DATAW-1:0] gdata;

   // keep a locked grant, otherwise take the first requester at or after rr_q
   always_comb begin
      gsel   = lsel_q;
      gvalid = lock_q;
      if (!lock_q)
         for (int k = NUM_SUBUNITS - 1; k >= 0; k--)
            if (rsp_valid[(32'(rr_q) + k) % NUM_SUBUNITS]) begin
               gsel   = SEL_BITS'((32'(rr_q) + k) % NUM_SUBUNITS);
               gvalid = 1'b1;
            end
   end

   assign gdata  = rsp_data[32'(gsel)*RSP_DATAW +: RSP_DATAW];
   assign fire   = gvalid && acc && rsp_valid[gsel];
   assign lock_d = gvalid && !fire;
   assign rr_d   = fire ? ((32'(gsel) == NUM_SUBUNITS - 1) ? '0 : gsel + 1'b1) : rr_q;

   // only the granted sub-unit may ever see ready
   always_comb begin
      rsp_ready       = '0;
      rsp_ready[gsel] = gvalid && acc;
   end

   // grant lock and round-robin pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q <= 1'b0;
         lsel_q <= '0;
         rr_q   <= '0;
      end else begin
         lock_q <= lock_d;
         lsel_q <= gsel;
         rr_q   <= rr_d;
      end
   end

   if (OUT_BUF != 0) begin : g_skid
      logic [RSP_DATAW-1:0] data_q [2];
      logic [SEL_BITS-1:0]  sel_q  [2];
      logic                 wr_q, rd_q, pop;
      logic [1:0]           cnt_q;

      assign acc       = cnt_q != 2'd2;
      assign pop       = out_valid && out_ready;
      assign out_valid = cnt_q != 2'd0;
      assign out_data  = data_q[rd_q];
      assign out_sel   = sel_q[rd_q];
      assign empty     = cnt_q == 2'd0;

      // skid occupancy and pointers
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
         end else begin
            wr_q  <= wr_q ^ fire;
            rd_q  <= rd_q ^ pop;
            cnt_q <= cnt_q + 2'(fire) - 2'(pop);
         end
      end

      // skid payload storage, capturing the granted commit
      always_ff @(posedge clk) begin
         if (fire) begin
            data_q[wr_q] <= gdata;
            sel_q[wr_q]  <= gsel;
         end
      end
   end else begin : g_comb
      assign acc       = out_ready;
      assign out_valid = gvalid && rsp_valid[gsel];
      assign out_data  = gdata;
      assign out_sel   = gsel;
      assign empty     = 1'b1;
   end

endmodule

// File: rtl/vx_alu_multi_unit.sv
// vx_alu_multi_unit: steers execute ops to sub-units, tracks credits, merges commits
module vx_alu_multi_unit
   import vx_alu_multi_pkg::*;
#(
   parameter int NUM_SUBUNITS = 2,
   parameter int TYPE_BITS    = 2,
   parameter int DATAW        = 128,
   parameter int RSP_DATAW    = 256,
   parameter int MAX_PENDING  = 4,
   parameter int OUT_BUF      = 1
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                exe_valid,
   input  logic [TYPE_BITS-1:0]                exe_type,
   input  logic [DATAW-1:0]                    exe_data,
   output logic                                exe_ready,
   input  logic                                fence,
   output logic [NUM_SUBUNITS-1:0]             sub_valid,
   output logic [DATAW-1:0]                    sub_data,
   input  logic [NUM_SUBUNITS-1:0]             sub_ready,
   input  logic [NUM_SUBUNITS-1:0]             rsp_valid,
   input  logic [NUM_SUBUNITS*RSP_DATAW-1:0]   rsp_data,
   output logic [NUM_SUBUNITS-1:0]             rsp_ready,
   output logic                                out_valid,
   output logic [RSP_DATAW-1:0]                out_data,
   output logic [sel_width(NUM_SUBUNITS)-1:0]  out_sel,
   input  logic                                out_ready,
   output logic                                idle
);

   localparam int SEL_BITS = sel_width(NUM_SUBUNITS);
   localparam int CNT_BITS = cnt_width(MAX_PENDING);

   logic [SEL_BITS-1:0]     sel;
   logic [CNT_BITS-1:0]     pend_q [NUM_SUBUNITS];
   logic [CNT_BITS-1:0]     pend_d [NUM_SUBUNITS];
   logic [NUM_SUBUNITS-1:0] busy, disp_fire, rsp_fire;
   logic                    any_pend, allow, buf_empty;

   // unmapped xtypes fall back to the int unit
   assign sel       = (32'(exe_type) < NUM_SUBUNITS) ? SEL_BITS'(exe_type) : '0;
   assign any_pend  = |busy;
   assign allow     = (32'(pend_q[sel]) < MAX_PENDING) && !(fence && any_pend);
   assign exe_ready = allow && sub_ready[sel];
   assign sub_data  = exe_data;
   assign disp_fire = sub_valid & sub_ready;
   assign rsp_fire  = rsp_valid & rsp_ready;
   assign idle      = !any_pend && buf_empty;

   // per-sub-unit outstanding flags
   always_comb begin
      busy = '0;
      for (int k = 0; k < NUM_SUBUNITS; k++) busy[k] = pend_q[k] != '0;
   end

   // one-hot dispatch to the selected sub-unit
   always_comb begin
      sub_valid = '0;
      for (int k = 0; k < NUM_SUBUNITS; k++) sub_valid[k] = exe_valid && allow && (32'(sel) == k);
   end

   // dispatch takes a credit, a commit returns one; a stray commit at zero is clamped
   always_comb begin
      for (int k = 0; k < NUM_SUBUNITS; k++)
         pend_d[k] = (disp_fire[k] && !rsp_fire[k]) ? pend_q[k] + 1'b1 :
                     (rsp_fire[k] && !disp_fire[k] && busy[k]) ? pend_q[k] - 1'b1 : pend_q[k];
   end

   // credit counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) for (int k = 0; k < NUM_SUBUNITS; k++) pend_q[k] <= '0;
      else       for (int k = 0; k < NUM_SUBUNITS; k++) pend_q[k] <= pend_d[k];
   end

   // a commit must never arrive from a sub-unit with nothing outstanding
   always @(posedge clk) begin
      for (int k = 0; k < NUM_SUBUNITS; k++)
         if (!reset) assert (!(rsp_fire[k] && !busy[k]));
   end

   vx_alu_rsp_arb #(
      .NUM_SUBUNITS (NUM_SUBUNITS),
      .RSP_DATAW    (RSP_DATAW),
      .OUT_BUF      (OUT_BUF)
   ) u_arb (
      .clk       (clk),
      .reset     (reset),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready),
      .empty     (buf_empty)
   );

endmodule

// File: tb/tb_vx_alu_multi_unit.sv
// tb_vx_alu_multi_unit: directed and random checks of the ALU multi-unit router
module tb_vx_alu_multi_unit;

   localparam int N = 2;

   logic           clk = 1'b0, reset = 1'b1;
   logic           exe_valid = 1'b0, exe_ready, fence = 1'b0, out_valid, out_ready = 1'b1, idle;
   logic [1:0]     exe_type = '0;
   logic [127:0]   exe_data = '0, sub_data;
   logic [N-1:0]   sub_valid, sub_ready = '1, rsp_valid = '0, rsp_ready;
   logic [N*256-1:0] rsp_data = '0;
   logic [255:0]   out_data;
   logic [0:0]     out_sel;

   always #5 clk = ~clk;

   vx_alu_multi_unit #(
      .NUM_SUBUNITS(N), .TYPE_BITS(2), .DATAW(128), .RSP_DATAW(256), .MAX_PENDING(4), .OUT_BUF(1)
   ) dut (
      .clk(clk), .reset(reset), .exe_valid(exe_valid), .exe_type(exe_type), .exe_data(exe_data),
      .exe_ready(exe_ready), .fence(fence), .sub_valid(sub_valid), .sub_data(sub_data),
      .sub_ready(sub_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_ready(out_ready), .idle(idle)
   );

   int vecs = 0, errs = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // model: outstanding ops per sub-unit, responses awaiting output, output order
   int            pend [N];
   logic [127:0]  subq [N][$];
   logic [255:0]  expq [N][$];
   int            skq [$];
   int            rr = 0, lock = -1, ndisp = 0;
   bit            fired [N];
   bit            auto_rsp = 1'b0;

   function automatic logic [255:0] payload(input logic [127:0] x);
      return {~x, x};
   endfunction

   function automatic int model_grant();
      if (lock >= 0) return lock;
      for (int k = 0; k < N; k++) if (rsp_valid[(rr + k) % N]) return (rr + k) % N;
      return -1;
   endfunction

   always @(negedge clk) begin
      int s, g, tot;
      logic allow;
      logic [N-1:0] sv, rdy;
      if (reset) begin
         for (int i = 0; i < N; i++) begin
            pend[i] = 0; subq[i].delete(); expq[i].delete(); fired[i] = 0;
         end
         skq.delete(); rr = 0; lock = -1;
      end else begin
         tot = 0;
         for (int i = 0; i < N; i++) tot += pend[i];
         s = (int'(exe_type) < N) ? int'(exe_type) : 0;
         allow = (pend[s] < 4) && !(fence && tot != 0);
         sv = '0;
         if (exe_valid && allow) sv[s] = 1'b1;
         g = model_grant();
         rdy = '0;
         if (g >= 0 && skq.size() < 2) rdy[g] = 1'b1;
         chk("exe_ready", exe_ready, allow && sub_ready[s]);
         chk("sub_valid", sub_valid, sv);
         chk("sub_data", sub_data, exe_data);
         chk("rsp_ready", rsp_ready, rdy);
         chk("out_valid", out_valid, skq.size() > 0);
         chk("idle", idle, tot == 0 && skq.size() == 0);
         if (skq.size() > 0) begin
            chk("out_sel", out_sel, skq[0]);
            chk("out_data", out_data, expq[skq[0]].size() > 0 ? expq[skq[0]][0] : '0);
            if (out_ready) begin
               if (expq[skq[0]].size() > 0) void'(expq[skq[0]].pop_front());
               void'(skq.pop_front());
            end
         end
         for (int i = 0; i < N; i++) begin
            fired[i] = rsp_valid[i] && rsp_ready[i];
            if (fired[i]) begin
               if (pend[i] > 0) pend[i]--;
               if (subq[i].size() > 0) void'(subq[i].pop_front());
               skq.push_back(i);
            end
         end
         if (g >= 0) begin
            if (fired[g]) begin lock = -1; rr = (g + 1) % N; end
            else lock = g;
         end
         for (int i = 0; i < N; i++)
            if (sv[i] && sub_ready[i]) begin
               pend[i]++;
               subq[i].push_back(exe_data);
               expq[i].push_back(payload(exe_data));
               ndisp++;
            end
      end
   end

   // advance one cycle; the bench acts as the sub-units presenting commits in order
   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (auto_rsp && !(rsp_valid[i] && !fired[i]))
            rsp_valid[i] = (subq[i].size() > 0) && ($urandom_range(0, 1) == 1);
         rsp_data[i*256 +: 256] = (subq[i].size() > 0) ? payload(subq[i][0]) : '0;
      end
   endtask

   task automatic send(input logic [1:0] t, input logic [127:0] d);
      exe_valid = 1'b1; exe_type = t; exe_data = d;
      step();
      exe_valid = 1'b0;
   endtask

   task automatic rsp(input logic [N-1:0] m);
      rsp_valid = m;
      step();
      rsp_valid = '0;
   endtask

   task automatic wait_idle(input int budget);
      auto_rsp = 1'b1;
      for (int c = 0; c < budget && !idle; c++) step();
      auto_rsp = 1'b0;
      rsp_valid = '0;
      chk("idle_reached", idle, 1'b1);
   endtask

   logic [0:0] sel_log [4];
   int start;

   initial begin
      repeat (2) step();
      reset = 1'b0;
      chk("init_idle", idle, 1'b1);
      chk("init_out_valid", out_valid, 1'b0);

      // steering: type 1 to unit 1, unmapped type 3 to unit 0
      exe_valid = 1'b1; exe_type = 2'd1; exe_data = 128'hA1;
      #1 chk("steer_t1", sub_valid, 2'b10);
      step();
      exe_type = 2'd3; exe_data = 128'hB2;
      #1 chk("steer_t3", sub_valid, 2'b01);
      step();
      exe_valid = 1'b0;
      send(2'd0, 128'hC3);
      send(2'd1, 128'hD4);

      // round robin with both units requesting
      rsp_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         step();
         sel_log[k] = out_sel;
      end
      rsp_valid = '0;
      chk("rr_0", sel_log[0], 1'b0);
      chk("rr_1", sel_log[1], 1'b1);
      chk("rr_2", sel_log[2], 1'b0);
      chk("rr_3", sel_log[3], 1'b1);
      step();

      // grant lock: unit 1 granted while stalled stays granted after unit 0 requests
      send(2'd0, 128'hE5);
      send(2'd1, 128'hF6);
      send(2'd1, 128'h17);
      send(2'd1, 128'h28);
      out_ready = 1'b0;
      rsp_valid = 2'b10;
      repeat (3) step();
      rsp_valid = 2'b11;
      repeat (2) begin
         step();
         chk("hold_data", out_data, payload(128'hF6));
         chk("hold_sel", out_sel, 1'b1);
         chk("hold_ready", rsp_ready, 2'b00);
      end
      out_ready = 1'b1;
      step();
      chk("lock_kept", rsp_ready, 2'b10);
      step();
      rsp_valid = 2'b01;
      step();
      rsp_valid = '0;
      wait_idle(50);

      // credits: four ops saturate unit 1
      for (int k = 0; k < 4; k++) send(2'd1, 128'(k + 'h40));
      exe_valid = 1'b1; exe_type = 2'd1; exe_data = 128'h99;
      #1 chk("credit_stall", exe_ready, 1'b0);
      rsp(2'b10);
      chk("credit_back", exe_ready, 1'b1);
      rsp(2'b10);
      step();
      chk("credit_full", exe_ready, 1'b0);
      exe_valid = 1'b0;
      wait_idle(100);

      // fence holds dispatch until every commit has fired
      send(2'd0, 128'h51);
      send(2'd0, 128'h52);
      send(2'd1, 128'h53);
      fence = 1'b1; exe_valid = 1'b1; exe_type = 2'd0; exe_data = 128'h54;
      #1 chk("fence_stall0", exe_ready, 1'b0);
      rsp(2'b01);
      chk("fence_stall1", exe_ready, 1'b0);
      rsp(2'b01);
      chk("fence_stall2", exe_ready, 1'b0);
      rsp(2'b10);
      chk("fence_release", exe_ready, 1'b1);
      step();
      exe_valid = 1'b0; fence = 1'b0;
      wait_idle(50);

      // reset mid-burst with two commits buffered
      send(2'd0, 128'h61);
      send(2'd1, 128'h62);
      out_ready = 1'b0;
      rsp(2'b01);
      rsp(2'b10);
      chk("pre_rst_valid", out_valid, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_idle", idle, 1'b1);
      step();
      step();
      reset = 1'b0; out_ready = 1'b1;
      chk("rst_ready", exe_ready, 1'b1);

      // random traffic with random back-pressure
      auto_rsp = 1'b1;
      start = ndisp;
      for (int c = 0; c < 5000 && ndisp - start < 100; c++) begin
         exe_valid = ($urandom_range(0, 3) != 0);
         exe_type  = 2'($urandom);
         exe_data  = {$urandom, $urandom, $urandom, $urandom};
         sub_ready = 2'($urandom);
         out_ready = $urandom_range(0, 1) == 1;
         fence     = $urandom_range(0, 7) == 0;
         step();
      end
      exe_valid = 1'b0; fence = 1'b0; out_ready = 1'b1; sub_ready = '1;
      chk("rand_ops", ndisp - start >= 100, 1'b1);
      wait_idle(300);
      chk("rand_drained", expq[0].size() + expq[1].size(), 0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
